// File: rtl/bp_me_cache_dma_to_bedrock_pkg.sv
// Shared types for the cache-DMA to BedRock bridge: message enums, header and DMA packet layouts.
// Header field order puts msg_type in the low bits so a packed header is easy to inspect.
package bp_me_cache_dma_to_bedrock_pkg;

  localparam int paddr_width_gp     = 40;
  localparam int cce_block_width_gp = 512;
  localparam int payload_width_gp   = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'b0000,
    e_bedrock_mem_wr    = 4'b0001,
    e_bedrock_mem_uc_rd = 4'b0010,
    e_bedrock_mem_uc_wr = 4'b0011
  } bp_bedrock_mem_type_e;

  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    logic                      write_not_read;
    logic [paddr_width_gp-1:0] addr;
  } bsg_cache_dma_pkt_s;

  localparam int dma_pkt_width_gp    = $bits(bsg_cache_dma_pkt_s);
  localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

  typedef enum logic {e_idle = 1'b0, e_wdata = 1'b1} cmd_state_e;
  typedef enum logic {e_hdr  = 1'b0, e_rdata = 1'b1} resp_state_e;

  // BedRock size encoding is log2 of the byte count
  function automatic bp_bedrock_msg_size_e bytes_to_size(input int bytes);
    return bp_bedrock_msg_size_e'(3'($clog2(bytes)));
  endfunction

endpackage

// File: rtl/bp_me_cache_dma_to_bedrock_tracker.sv
// In-order tracker of outstanding memory commands: a small 1r1w FIFO of {channel id, is_write}.
// Push is refused while full as seen at the start of the cycle; a same-cycle pop does not bypass.
module bp_me_cache_dma_to_bedrock_tracker
  import bp_me_cache_dma_to_bedrock_pkg::*;
#(
  parameter int width_p = 2,
  parameter int els_p   = 4
)
(
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               full_o,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    push_s, pop_s;

  assign full_o  = (cnt_q == cnt_width_lp'(els_p));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rptr_q];
  assign push_s  = v_i & ~full_o;
  assign pop_s   = yumi_i & ~empty_o;

  // pointer and occupancy next state
  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (push_s) begin
      wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + ptr_width_lp'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + ptr_width_lp'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + cnt_width_lp'(1);
      2'b01:   cnt_d = cnt_q - cnt_width_lp'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // entry storage; contents are dead whenever the pointers say so
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/bp_me_cache_dma_to_bedrock.sv
// Bridges num_dma_p bsg_cache DMA ports onto one BedRock mem cmd/resp stream pair with
// round-robin command arbitration and strictly in-order response routing.
module bp_me_cache_dma_to_bedrock
  import bp_me_cache_dma_to_bedrock_pkg::*;
#(
  parameter int num_dma_p         = 2,
  parameter int data_width_p      = 64,
  parameter int block_width_p     = cce_block_width_gp,
  parameter int max_outstanding_p = 4,
  localparam int dma_pkt_width_lp    = dma_pkt_width_gp,
  localparam int mem_header_width_lp = mem_header_width_gp
)
(
  input  logic                                  clk_i,
  input  logic                                  reset_i,

  input  logic [num_dma_p*dma_pkt_width_lp-1:0] dma_pkt_i,
  input  logic [num_dma_p-1:0]                  dma_pkt_v_i,
  output logic [num_dma_p-1:0]                  dma_pkt_yumi_o,

  output logic [data_width_p-1:0]               dma_data_o,
  output logic [num_dma_p-1:0]                  dma_data_v_o,
  input  logic [num_dma_p-1:0]                  dma_data_ready_i,

  input  logic [num_dma_p*data_width_p-1:0]     dma_data_i,
  input  logic [num_dma_p-1:0]                  dma_data_v_i,
  output logic [num_dma_p-1:0]                  dma_data_yumi_o,

  output logic [mem_header_width_lp-1:0]        mem_cmd_header_o,
  output logic                                  mem_cmd_header_v_o,
  input  logic                                  mem_cmd_header_yumi_i,
  output logic [data_width_p-1:0]               mem_cmd_data_o,
  output logic                                  mem_cmd_data_v_o,
  input  logic                                  mem_cmd_data_yumi_i,

  input  logic [mem_header_width_lp-1:0]        mem_resp_header_i,
  input  logic                                  mem_resp_header_v_i,
  output logic                                  mem_resp_header_ready_o,
  input  logic [data_width_p-1:0]               mem_resp_data_i,
  input  logic                                  mem_resp_data_v_i,
  output logic                                  mem_resp_data_ready_o,

  output logic                                  error_o
);

  localparam int beats_lp       = block_width_p / data_width_p;
  localparam int cnt_width_lp   = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int id_width_lp    = (num_dma_p > 1) ? $clog2(num_dma_p) : 1;
  localparam int entry_width_lp = id_width_lp + 1;
  localparam logic [cnt_width_lp-1:0]  last_beat_lp = cnt_width_lp'(beats_lp - 1);
  localparam logic [id_width_lp-1:0]   last_id_lp   = id_width_lp'(num_dma_p - 1);
  localparam bp_bedrock_msg_size_e     size_lp      = bytes_to_size(block_width_p / 8);

  cmd_state_e                cmd_state_q, cmd_state_d;
  resp_state_e               resp_state_q, resp_state_d;
  logic [id_width_lp-1:0]    rr_q, rr_d, wid_q, wid_d, grant_id_s, head_id_s;
  logic [cnt_width_lp-1:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic                      error_q, error_d;
  logic                      grant_found_s, push_s, pop_s, tr_full_s, tr_empty_s, head_is_wr_s;
  logic [entry_width_lp-1:0] tr_head_s;
  bsg_cache_dma_pkt_s        grant_pkt_s;
  bp_bedrock_mem_header_s    cmd_hdr_s, resp_hdr_s;
  logic                      unused_s;

  bp_me_cache_dma_to_bedrock_tracker #(
    .width_p (entry_width_lp),
    .els_p   (max_outstanding_p)
  ) tracker (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  ({grant_id_s, grant_pkt_s.write_not_read}),
    .v_i     (push_s),
    .full_o  (tr_full_s),
    .data_o  (tr_head_s),
    .empty_o (tr_empty_s),
    .yumi_i  (pop_s)
  );

  assign head_id_s        = tr_head_s[entry_width_lp-1:1];
  assign head_is_wr_s     = tr_head_s[0];
  assign resp_hdr_s       = bp_bedrock_mem_header_s'(mem_resp_header_i);
  assign unused_s         = ^{resp_hdr_s.payload, resp_hdr_s.size, resp_hdr_s.addr};
  assign grant_pkt_s      = bsg_cache_dma_pkt_s'(dma_pkt_i[int'(grant_id_s)*dma_pkt_width_lp +: dma_pkt_width_lp]);
  assign mem_cmd_header_o = cmd_hdr_s;
  assign error_o          = error_q;

  // round-robin search starting at rr_q; stable while the granted valid is held
  always_comb begin
    grant_found_s = 1'b0;
    grant_id_s    = rr_q;
    for (int i = 0; i < num_dma_p; i++) begin
      if (!grant_found_s && dma_pkt_v_i[(int'(rr_q) + i) % num_dma_p]) begin
        grant_found_s = 1'b1;
        grant_id_s    = id_width_lp'((int'(rr_q) + i) % num_dma_p);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // command FSM: header issue from the granted packet, then eviction beats for writes
  always_comb begin
    cmd_state_d        = cmd_state_q;
    wid_d              = wid_q;
    wcnt_d             = wcnt_q;
    rr_d               = rr_q;
    push_s             = 1'b0;
    dma_pkt_yumi_o     = '0;
    dma_data_yumi_o    = '0;
    mem_cmd_header_v_o = 1'b0;
    mem_cmd_data_v_o   = 1'b0;
    mem_cmd_data_o     = dma_data_i[int'(wid_q)*data_width_p +: data_width_p];
    cmd_hdr_s          = '0;
    cmd_hdr_s.msg_type = grant_pkt_s.write_not_read ? e_bedrock_mem_wr : e_bedrock_mem_rd;
    cmd_hdr_s.addr     = grant_pkt_s.addr;
    cmd_hdr_s.size     = size_lp;
    case (cmd_state_q)
      e_idle: begin
        mem_cmd_header_v_o = grant_found_s & ~tr_full_s;
        if (mem_cmd_header_v_o && mem_cmd_header_yumi_i) begin
          dma_pkt_yumi_o[grant_id_s] = 1'b1;
          push_s = 1'b1;
          rr_d   = (grant_id_s == last_id_lp) ? '0 : grant_id_s + id_width_lp'(1);
          if (grant_pkt_s.write_not_read) begin
            cmd_state_d = e_wdata;
            wid_d       = grant_id_s;
            wcnt_d      = '0;
          end else begin
            cmd_state_d = e_idle;
          end
        end else begin
          cmd_state_d = e_idle;
        end
      end
      e_wdata: begin
        mem_cmd_data_v_o         = dma_data_v_i[wid_q];
        dma_data_yumi_o[wid_q]   = mem_cmd_data_yumi_i;
        if (mem_cmd_data_yumi_i) begin
          wcnt_d = (wcnt_q == last_beat_lp) ? '0 : wcnt_q + cnt_width_lp'(1);
          cmd_state_d = (wcnt_q == last_beat_lp) ? e_idle : e_wdata;
        end else begin
          cmd_state_d = e_wdata;
        end
      end
      default: cmd_state_d = e_idle;
    endcase
  end

  // response FSM: match headers to the tracker head, route read beats to the owning channel
  always_comb begin
    resp_state_d            = resp_state_q;
    rcnt_d                  = rcnt_q;
    error_d                 = error_q;
    pop_s                   = 1'b0;
    mem_resp_header_ready_o = 1'b0;
    mem_resp_data_ready_o   = 1'b0;
    dma_data_v_o            = '0;
    dma_data_o              = mem_resp_data_i;
    case (resp_state_q)
      e_hdr: begin
        mem_resp_header_ready_o = ~tr_empty_s;
        if (mem_resp_data_v_i) begin
          error_d = 1'b1;
        end else begin
          error_d = error_q;
        end
        if (mem_resp_header_v_i && mem_resp_header_ready_o) begin
          if ((resp_hdr_s.msg_type == e_bedrock_mem_wr) != head_is_wr_s) begin
            error_d = 1'b1;
          end else begin
            error_d = error_d;
          end
          if (head_is_wr_s) begin
            pop_s = 1'b1;
          end else begin
            resp_state_d = e_rdata;
            rcnt_d       = '0;
          end
        end else if (mem_resp_header_v_i) begin
          error_d = 1'b1;
        end else begin
          resp_state_d = e_hdr;
        end
      end
      e_rdata: begin
        dma_data_v_o[head_id_s] = mem_resp_data_v_i;
        mem_resp_data_ready_o   = dma_data_ready_i[head_id_s];
        if (mem_resp_data_v_i && mem_resp_data_ready_o) begin
          rcnt_d       = (rcnt_q == last_beat_lp) ? '0 : rcnt_q + cnt_width_lp'(1);
          pop_s        = (rcnt_q == last_beat_lp);
          resp_state_d = (rcnt_q == last_beat_lp) ? e_hdr : e_rdata;
        end else begin
          resp_state_d = e_rdata;
        end
      end
      default: resp_state_d = e_hdr;
    endcase
  end

  // state registers for both FSMs, arbiter pointer and sticky error
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cmd_state_q  <= e_idle;
      resp_state_q <= e_hdr;
      rr_q         <= '0;
      wid_q        <= '0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      error_q      <= 1'b0;
    end else begin
      cmd_state_q  <= cmd_state_d;
      resp_state_q <= resp_state_d;
      rr_q         <= rr_d;
      wid_q        <= wid_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_bp_me_cache_dma_to_bedrock.sv
// Scoreboard bench: stimulus pushes expected headers/beats into queues; a negedge monitor pops
// and compares whenever the bridge completes a handshake.
module tb_bp_me_cache_dma_to_bedrock;
  import bp_me_cache_dma_to_bedrock_pkg::*;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int PW = dma_pkt_width_gp;
  localparam int HW = mem_header_width_gp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic [N*PW-1:0]   dma_pkt_i;
  logic [N-1:0]      dma_pkt_v_i, dma_pkt_yumi_o;
  logic [DW-1:0]     dma_data_o;
  logic [N-1:0]      dma_data_v_o, dma_data_ready_i;
  logic [N*DW-1:0]   dma_data_i;
  logic [N-1:0]      dma_data_v_i, dma_data_yumi_o;
  logic [HW-1:0]     mem_cmd_header_o, mem_resp_header_i;
  logic              mem_cmd_header_v_o, mem_cmd_header_yumi_i;
  logic [DW-1:0]     mem_cmd_data_o, mem_resp_data_i;
  logic              mem_cmd_data_v_o, mem_cmd_data_yumi_i;
  logic              mem_resp_header_v_i, mem_resp_header_ready_o;
  logic              mem_resp_data_v_i, mem_resp_data_ready_o;
  logic              error_o;
  logic              hdr_en, wd_en;

  assign mem_cmd_header_yumi_i = mem_cmd_header_v_o & hdr_en;
  assign mem_cmd_data_yumi_i   = mem_cmd_data_v_o & wd_en;

  bp_me_cache_dma_to_bedrock dut (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .mem_cmd_header_o(mem_cmd_header_o), .mem_cmd_header_v_o(mem_cmd_header_v_o),
    .mem_cmd_header_yumi_i(mem_cmd_header_yumi_i),
    .mem_cmd_data_o(mem_cmd_data_o), .mem_cmd_data_v_o(mem_cmd_data_v_o),
    .mem_cmd_data_yumi_i(mem_cmd_data_yumi_i),
    .mem_resp_header_i(mem_resp_header_i), .mem_resp_header_v_i(mem_resp_header_v_i),
    .mem_resp_header_ready_o(mem_resp_header_ready_o),
    .mem_resp_data_i(mem_resp_data_i), .mem_resp_data_v_i(mem_resp_data_v_i),
    .mem_resp_data_ready_o(mem_resp_data_ready_o),
    .error_o(error_o)
  );

  typedef struct {int ch; logic is_wr; logic [39:0] addr;} exp_hdr_t;
  typedef struct {int ch; logic [63:0] data;} exp_beat_t;

  exp_hdr_t           exp_hdr_q[$];
  exp_beat_t          exp_wdata_q[$];
  exp_beat_t          exp_fill_q[$];
  bsg_cache_dma_pkt_s pkt_q[N][$];
  logic [63:0]        wq[N][$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    bp_bedrock_mem_header_s h;
    exp_hdr_t  eh;
    exp_beat_t eb;
    if (!reset_i) begin
      if (mem_cmd_header_v_o && mem_cmd_header_yumi_i) begin
        h = bp_bedrock_mem_header_s'(mem_cmd_header_o);
        if (exp_hdr_q.size() == 0) begin
          check("hdr_unexpected", 64'(h.addr), 64'hFFFF_FFFF);
        end else begin
          eh = exp_hdr_q.pop_front();
          check("hdr_type", 64'(h.msg_type), eh.is_wr ? 64'(e_bedrock_mem_wr) : 64'(e_bedrock_mem_rd));
          check("hdr_addr", 64'(h.addr), 64'(eh.addr));
          check("hdr_size", 64'(h.size), 64'(e_bedrock_msg_size_64));
          check("hdr_pkt_yumi", 64'(dma_pkt_yumi_o), 64'(2'b01 << eh.ch));
        end
      end
      if (mem_cmd_data_v_o && mem_cmd_data_yumi_i) begin
        if (exp_wdata_q.size() == 0) begin
          check("wdata_unexpected", mem_cmd_data_o, 64'hFFFF_FFFF);
        end else begin
          eb = exp_wdata_q.pop_front();
          check("wdata", mem_cmd_data_o, eb.data);
          check("wdata_yumi", 64'(dma_data_yumi_o), 64'(2'b01 << eb.ch));
        end
      end
      if ((dma_data_v_o & dma_data_ready_i) != '0) begin
        if (exp_fill_q.size() == 0) begin
          check("fill_unexpected", dma_data_o, 64'hFFFF_FFFF);
        end else begin
          eb = exp_fill_q.pop_front();
          check("fill_data", dma_data_o, eb.data);
          check("fill_route", 64'(dma_data_v_o), 64'(2'b01 << eb.ch));
        end
      end
    end
  end

  // DMA-side channel drivers fed from per-channel queues
  logic [N-1:0] pyumi, dyumi;
  initial begin
    dma_pkt_v_i  = '0;
    dma_pkt_i    = '0;
    dma_data_v_i = '0;
    dma_data_i   = '0;
    forever begin
      @(negedge clk);
      pyumi = dma_pkt_yumi_o;
      dyumi = dma_data_yumi_o;
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (pyumi[c] && pkt_q[c].size() > 0) void'(pkt_q[c].pop_front());
        if (dyumi[c] && wq[c].size() > 0) void'(wq[c].pop_front());
        dma_pkt_v_i[c]          = (pkt_q[c].size() > 0);
        dma_pkt_i[c*PW +: PW]   = (pkt_q[c].size() > 0) ? pkt_q[c][0] : '0;
        dma_data_v_i[c]         = (wq[c].size() > 0);
        dma_data_i[c*DW +: DW]  = (wq[c].size() > 0) ? wq[c][0] : '0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int qsize(input int which);
    case (which)
      0:       return exp_hdr_q.size();
      1:       return exp_wdata_q.size();
      default: return exp_fill_q.size();
    endcase
  endfunction

  task automatic wait_left(input int which, input int n, input string name);
    int k = 0;
    while (qsize(which) > n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(qsize(which)), 64'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int ch, input logic is_wr, input logic [39:0] addr);
    bsg_cache_dma_pkt_s p;
    exp_hdr_t e;
    p.write_not_read = is_wr;
    p.addr = addr;
    e.ch = ch; e.is_wr = is_wr; e.addr = addr;
    exp_hdr_q.push_back(e);
    pkt_q[ch].push_back(p);
  endtask

  task automatic send_resp_hdr(input logic is_wr, input logic [39:0] addr);
    bp_bedrock_mem_header_s h;
    bit ok = 1'b0;
    h = '0;
    h.msg_type = is_wr ? e_bedrock_mem_wr : e_bedrock_mem_rd;
    h.addr = addr;
    h.size = e_bedrock_msg_size_64;
    mem_resp_header_i = h;
    mem_resp_header_v_i = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = mem_resp_header_ready_o;
    end
    if (!ok) check("resp_hdr_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    mem_resp_header_v_i = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d);
    bit ok = 1'b0;
    mem_resp_data_i = d;
    mem_resp_data_v_i = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = mem_resp_data_ready_o;
    end
    if (!ok) check("resp_data_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    mem_resp_data_v_i = 1'b0;
  endtask

  task automatic read_resp(input int ch, input logic [39:0] addr, input logic [63:0] base);
    exp_beat_t e;
    for (int b = 0; b < 8; b++) begin
      e.ch = ch; e.data = base + 64'(b);
      exp_fill_q.push_back(e);
    end
    send_resp_hdr(1'b0, addr);
    for (int b = 0; b < 8; b++) send_beat(base + 64'(b));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    mem_resp_header_v_i = 1'b0;
    mem_resp_data_v_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  initial begin
    exp_beat_t e;
    reset_i = 1'b1;
    hdr_en = 1'b1;
    wd_en = 1'b1;
    dma_data_ready_i = '1;
    mem_resp_header_i = '0;
    mem_resp_header_v_i = 1'b0;
    mem_resp_data_i = '0;
    mem_resp_data_v_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    check("rst_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
    check("rst_cmd_v", 64'({mem_cmd_header_v_o, mem_cmd_data_v_o}), 64'd0);
    check("rst_dma_v", 64'({dma_data_v_o, dma_data_yumi_o}), 64'd0);
    check("rst_resp_ready", 64'({mem_resp_header_ready_o, mem_resp_data_ready_o}), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    @(posedge clk);
    #1;

    // single read on ch0
    issue(0, 1'b0, 40'h80_0000_40);
    wait_left(0, 0, "rd_hdr_issued");
    read_resp(0, 40'h80_0000_40, 64'd0);
    wait_left(2, 0, "rd_fill_done");
    @(negedge clk);
    check("rd_tracker_empty", 64'(mem_resp_header_ready_o), 64'd0);
    @(posedge clk);
    #1;

    // eviction from ch1
    for (int b = 0; b < 8; b++) begin
      e.ch = 1; e.data = 64'hA0 + 64'(b);
      exp_wdata_q.push_back(e);
      wq[1].push_back(64'hA0 + 64'(b));
    end
    issue(1, 1'b1, 40'h80_0000_1000);
    wait_left(0, 0, "wr_hdr_issued");
    wait_left(1, 0, "wr_data_done");
    send_resp_hdr(1'b1, 40'h80_0000_1000);
    @(negedge clk);
    check("wr_ack_popped", 64'(mem_resp_header_ready_o), 64'd0);
    check("wr_no_error", 64'(error_o), 64'd0);
    check("wr_no_fill", 64'(dma_data_v_o), 64'd0);
    @(posedge clk);
    #1;

    // both channels contend: grants alternate 0,1,0,1
    issue(0, 1'b0, 40'h80_0000_0A00);
    issue(1, 1'b0, 40'h80_0000_0B00);
    issue(0, 1'b0, 40'h80_0000_0A40);
    issue(1, 1'b0, 40'h80_0000_0B40);
    pkt_q[0].delete();
    pkt_q[1].delete();
    begin
      bsg_cache_dma_pkt_s p;
      p.write_not_read = 1'b0;
      p.addr = 40'h80_0000_0A00; pkt_q[0].push_back(p);
      p.addr = 40'h80_0000_0A40; pkt_q[0].push_back(p);
      p.addr = 40'h80_0000_0B00; pkt_q[1].push_back(p);
      p.addr = 40'h80_0000_0B40; pkt_q[1].push_back(p);
    end
    exp_hdr_q.delete();
    begin
      exp_hdr_t h;
      h.is_wr = 1'b0;
      h.ch = 0; h.addr = 40'h80_0000_0A00; exp_hdr_q.push_back(h);
      h.ch = 1; h.addr = 40'h80_0000_0B00; exp_hdr_q.push_back(h);
      h.ch = 0; h.addr = 40'h80_0000_0A40; exp_hdr_q.push_back(h);
      h.ch = 1; h.addr = 40'h80_0000_0B40; exp_hdr_q.push_back(h);
    end
    wait_left(0, 0, "rr_hdrs_issued");
    read_resp(0, 40'h80_0000_0A00, 64'h100);
    read_resp(1, 40'h80_0000_0B00, 64'h110);
    read_resp(0, 40'h80_0000_0A40, 64'h120);
    read_resp(1, 40'h80_0000_0B40, 64'h130);
    wait_left(2, 0, "rr_fill_done");

    // tracker full: fifth read held until the first read retires
    for (int i = 0; i < 5; i++) issue(0, 1'b0, 40'h80_0000_2000 + 40'(i * 64));
    wait_left(0, 1, "full_four_issued");
    repeat (10) @(negedge clk);
    check("full_no_pkt_yumi", 64'(dma_pkt_yumi_o), 64'd0);
    check("full_no_hdr_v", 64'(mem_cmd_header_v_o), 64'd0);
    check("full_fifth_pending", 64'(exp_hdr_q.size()), 64'd1);
    @(posedge clk);
    #1;
    for (int b = 0; b < 8; b++) begin
      e.ch = 0; e.data = 64'h200 + 64'(b);
      exp_fill_q.push_back(e);
    end
    send_resp_hdr(1'b0, 40'h80_0000_2000);
    for (int b = 0; b < 3; b++) send_beat(64'h200 + 64'(b));
    mem_resp_data_i = 64'h203;
    mem_resp_data_v_i = 1'b1;
    dma_data_ready_i[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_resp_ready", 64'(mem_resp_data_ready_o), 64'd0);
      check("bp_fill_v", 64'(dma_data_v_o), 64'd1);
      @(posedge clk);
      #1;
    end
    dma_data_ready_i[0] = 1'b1;
    for (int b = 3; b < 8; b++) send_beat(64'h200 + 64'(b));
    wait_left(0, 0, "full_fifth_issued");
    for (int i = 1; i < 5; i++) read_resp(0, 40'h80_0000_2000 + 40'(i * 64), 64'h300 + 64'(i * 16));
    wait_left(2, 0, "full_fill_done");
    @(negedge clk);
    check("full_tracker_empty", 64'(mem_resp_header_ready_o), 64'd0);
    check("full_no_error", 64'(error_o), 64'd0);
    @(posedge clk);
    #1;

    // response beat with nothing outstanding
    mem_resp_data_i = 64'hDEAD;
    mem_resp_data_v_i = 1'b1;
    @(negedge clk);
    check("err_beat_refused", 64'(mem_resp_data_ready_o), 64'd0);
    @(posedge clk);
    #1;
    mem_resp_data_v_i = 1'b0;
    @(negedge clk);
    check("err_set", 64'(error_o), 64'd1);
    repeat (5) @(negedge clk);
    check("err_sticky", 64'(error_o), 64'd1);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("err_cleared_by_reset", 64'(error_o), 64'd0);
    @(posedge clk);
    #1;

    // reset in the middle of an eviction
    for (int b = 0; b < 3; b++) begin
      e.ch = 0; e.data = 64'hC0 + 64'(b);
      exp_wdata_q.push_back(e);
      wq[0].push_back(64'hC0 + 64'(b));
    end
    issue(0, 1'b1, 40'h80_0000_3000);
    wait_left(0, 0, "mid_wr_hdr");
    wait_left(1, 0, "mid_wr_beats");
    pkt_q[1].push_back('{write_not_read: 1'b0, addr: 40'h80_0000_4000});
    repeat (5) @(negedge clk);
    check("mid_wr_hdr_blocked", 64'(mem_cmd_header_v_o), 64'd0);
    check("mid_wr_data_idle", 64'(mem_cmd_data_v_o), 64'd0);
    @(posedge clk);
    #1;
    pkt_q[0].delete();
    pkt_q[1].delete();
    wq[0].delete();
    wq[1].delete();
    do_reset();
    @(negedge clk);
    check("post_rst_cmd_v", 64'({mem_cmd_header_v_o, mem_cmd_data_v_o}), 64'd0);
    check("post_rst_yumi", 64'({dma_pkt_yumi_o, dma_data_yumi_o}), 64'd0);
    check("post_rst_resp", 64'({mem_resp_header_ready_o, mem_resp_data_ready_o, dma_data_v_o}), 64'd0);
    check("post_rst_error", 64'(error_o), 64'd0);
    check("post_rst_scoreboard", 64'(exp_hdr_q.size() + exp_wdata_q.size() + exp_fill_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
